treasure_classifier: RTL

- Downstream consumer of the camera downsampler's per-pixel stream (RGB332 pixel, coordinates, write strobe).
- Per frame, it counts red- and blue-dominant pixels and measures object width on three horizontal sample rows.
- At frame end it classifies the treasure colour and shape, then publishes a registered result to the Arduino-facing output pins.

---
 rtl/treasure_classifier_pkg.sv | 37 +++
 rtl/treasure_classifier_if.sv | 22 ++
 rtl/treasure_band_counter.sv | 25 ++
 rtl/treasure_classifier.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/treasure_classifier_pkg.sv
// Shared codes, FSM encoding and counter widths for the treasure classifier.
package treasure_classifier_pkg;

    typedef enum logic [1:0] {
        COLOR_NONE = 2'b00,
        COLOR_RED  = 2'b01,
        COLOR_BLUE = 2'b10
    } color_t;

    typedef enum logic [1:0] {
        SHAPE_NONE    = 2'b00,
        SHAPE_TRI     = 2'b01,
        SHAPE_SQUARE  = 2'b10,
        SHAPE_DIAMOND = 2'b11
    } shape_t;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'b00,
        ST_COLOR  = 2'b01,
        ST_SHAPE  = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    localparam int TOT_W   = 15;
    localparam int BAND_W  = 8;
    localparam int MATCH_W = 3;

    // Consecutive identical decisions needed before publishing (stable filter only).
    localparam int STABLE_FRAMES = 3;

    // Magnitude of a difference, one bit wider so callers compare without wrap.
    function automatic logic [BAND_W:0] abs_diff(input logic [BAND_W-1:0] a,
                                                 input logic [BAND_W-1:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage

// File: rtl/treasure_classifier_if.sv
// Pixel stream in, classification result out.
interface treasure_classifier_if;
    logic       PIXEL_VALID;
    logic [7:0] PIXEL_DATA;
    logic [7:0] PIXEL_X;
    logic [7:0] PIXEL_Y;
    logic       FRAME_END;
    logic [1:0] RESULT_COLOR;
    logic [1:0] RESULT_SHAPE;
    logic       RESULT_VALID;
    logic       BUSY;

    modport master (
        output PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y, FRAME_END,
        input  RESULT_COLOR, RESULT_SHAPE, RESULT_VALID, BUSY
    );

    modport slave (
        input  PIXEL_VALID, PIXEL_DATA, PIXEL_X, PIXEL_Y, FRAME_END,
        output RESULT_COLOR, RESULT_SHAPE, RESULT_VALID, BUSY
    );
endinterface

// File: rtl/treasure_band_counter.sv
// Saturating width counter for one colour on one sample row.
// count_next exposes the value including this cycle's increment so the
// parent can snapshot it in the same cycle the counter is cleared.
module treasure_band_counter
    import treasure_classifier_pkg::*;
#(
    parameter logic [BAND_W-1:0] MAX_COUNT = 8'd176
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [BAND_W-1:0] count,
    output logic [BAND_W-1:0] count_next
);

    assign count_next = (inc && (count < MAX_COUNT)) ? count + BAND_W'(1) : count;

    // Live count: cleared at frame end, otherwise follows count_next.
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else            count <= count_next;
    end

endmodule

// File: rtl/treasure_classifier.sv
// Frame-level treasure colour/shape classifier fed by the downsampled pixel stream.
// Optional macro TREASURE_STABLE_FILTER_EN: publish only after STABLE_FRAMES
// consecutive identical decisions.
module treasure_classifier
    import treasure_classifier_pkg::*;
#(
    parameter int              IMG_WIDTH = 176,
    parameter logic [7:0]      ROW_TOP   = 8'd40,
    parameter logic [7:0]      ROW_MID   = 8'd72,
    parameter logic [7:0]      ROW_BOT   = 8'd104,
    parameter logic [2:0]      CH_MIN    = 3'd4,
    parameter logic [2:0]      CH_MAX    = 3'd3,
    parameter logic [TOT_W-1:0] MIN_COUNT = 15'd1000,
    parameter logic [BAND_W-1:0] TOL     = 8'd6
) (
    input logic                  CLK,
    input logic                  RESET,
    treasure_classifier_if.slave bus
);

    logic [2:0] ch_r, ch_g, ch_b;
    logic       is_red, is_blue;
    logic [2:0] row_hit;

    // Column index is not needed: band width is simply the pixel count on the row.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.PIXEL_X};

    assign ch_r = bus.PIXEL_DATA[7:5];
    assign ch_g = bus.PIXEL_DATA[4:2];
    assign ch_b = {bus.PIXEL_DATA[1:0], bus.PIXEL_DATA[1]};

    assign is_red  = bus.PIXEL_VALID && (ch_r >= CH_MIN) && (ch_g <= CH_MAX) && (ch_b <= CH_MAX);
    assign is_blue = bus.PIXEL_VALID && (ch_b >= CH_MIN) && (ch_r <= CH_MAX) && (ch_g <= CH_MAX);

    assign row_hit[0] = (bus.PIXEL_Y == ROW_TOP);
    assign row_hit[1] = (bus.PIXEL_Y == ROW_MID);
    assign row_hit[2] = (bus.PIXEL_Y == ROW_BOT);

    // Band counters: index 0..2 red top/mid/bot, 3..5 blue top/mid/bot.
    logic [BAND_W-1:0] band_now  [6];
    logic [BAND_W-1:0] band_next [6];
    logic [BAND_W-1:0] band_snap [6];
    logic [5:0]        band_inc;

    for (genvar gi = 0; gi < 6; gi++) begin : g_band
        assign band_inc[gi] = ((gi < 3) ? is_red : is_blue) && row_hit[gi % 3];

        treasure_band_counter #(.MAX_COUNT(BAND_W'(IMG_WIDTH))) u_band (
            .clk        (CLK),
            .rst        (RESET),
            .clr        (bus.FRAME_END),
            .inc        (band_inc[gi]),
            .count      (band_now[gi]),
            .count_next (band_next[gi])
        );
    end

    logic [TOT_W-1:0] red_tot, blue_tot, red_next, blue_next, red_snap, blue_snap;

    assign red_next  = (is_red  && (red_tot  != {TOT_W{1'b1}})) ? red_tot  + TOT_W'(1) : red_tot;
    assign blue_next = (is_blue && (blue_tot != {TOT_W{1'b1}})) ? blue_tot + TOT_W'(1) : blue_tot;

    // Frame totals and snapshots; every FRAME_END snapshots, even while busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            red_tot   <= '0;
            blue_tot  <= '0;
            red_snap  <= '0;
            blue_snap <= '0;
            for (int i = 0; i < 6; i++) band_snap[i] <= '0;
        end else if (bus.FRAME_END) begin
            red_tot   <= '0;
            blue_tot  <= '0;
            red_snap  <= red_next;
            blue_snap <= blue_next;
            for (int i = 0; i < 6; i++) band_snap[i] <= band_next[i];
        end else begin
            red_tot  <= red_next;
            blue_tot <= blue_next;
        end
    end

    state_t state, state_next;
    logic   busy;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_ACCUM;
        else       state <= state_next;
    end

    // Next state and busy flag; a FRAME_END outside ACCUM starts nothing.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            ST_ACCUM: begin
                busy = 1'b0;
                if (bus.FRAME_END) state_next = ST_COLOR;
            end
            ST_COLOR:  state_next = ST_SHAPE;
            ST_SHAPE:  state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_ACCUM;
            default:   state_next = ST_ACCUM;
        endcase
    end

    assign bus.BUSY = busy;

    color_t            color_pick, color_r;
    logic [BAND_W-1:0] t_w, m_w, b_w;

    // Colour decision from snapshot totals; ties favour red.
    always_comb begin
        color_pick = COLOR_NONE;
        if (!((red_snap < MIN_COUNT) && (blue_snap < MIN_COUNT)))
            color_pick = (red_snap >= blue_snap) ? COLOR_RED : COLOR_BLUE;
    end

    // Latch colour and that colour's three band widths.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            color_r <= COLOR_NONE;
            t_w     <= '0;
            m_w     <= '0;
            b_w     <= '0;
        end else if (state == ST_COLOR) begin
            color_r <= color_pick;
            t_w     <= (color_pick == COLOR_RED) ? band_snap[0] : band_snap[3];
            m_w     <= (color_pick == COLOR_RED) ? band_snap[1] : band_snap[4];
            b_w     <= (color_pick == COLOR_RED) ? band_snap[2] : band_snap[5];
        end
    end

    logic [BAND_W:0] t_x, m_x, b_x, tol_x;
    shape_t          shape_pick, shape_r;

    assign t_x   = {1'b0, t_w};
    assign m_x   = {1'b0, m_w};
    assign b_x   = {1'b0, b_w};
    assign tol_x = {1'b0, TOL};

    // Shape decision in priority order on widened operands.
    always_comb begin
        shape_pick = SHAPE_NONE;
        if (color_r == COLOR_NONE)
            shape_pick = SHAPE_NONE;
        else if ((abs_diff(t_w, m_w) <= tol_x) && (abs_diff(m_w, b_w) <= tol_x) && (t_w != '0))
            shape_pick = SHAPE_SQUARE;
        else if ((b_x > t_x + tol_x) && (m_x > t_x))
            shape_pick = SHAPE_TRI;
        else if ((m_x > t_x + tol_x) && (m_x > b_x + tol_x))
            shape_pick = SHAPE_DIAMOND;
    end

    // Hold the shape decision for COMMIT.
    always_ff @(posedge CLK) begin
        if (RESET)                  shape_r <= SHAPE_NONE;
        else if (state == ST_SHAPE) shape_r <= shape_pick;
    end

    logic publish;

`ifdef TREASURE_STABLE_FILTER_EN
    logic [1:0]         prev_color, prev_shape;
    logic [MATCH_W-1:0] match_cnt, match_new;

    // Run length of identical decisions, saturating at the publish threshold.
    always_comb begin
        match_new = MATCH_W'(1);
        if ({color_r, shape_r} == {prev_color, prev_shape})
            match_new = (match_cnt >= MATCH_W'(STABLE_FRAMES)) ? match_cnt : match_cnt + MATCH_W'(1);
    end

    assign publish = (match_new >= MATCH_W'(STABLE_FRAMES));

    // Remember the last decision and its run length.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_color <= '0;
            prev_shape <= '0;
            match_cnt  <= '0;
        end else if (state == ST_COMMIT) begin
            prev_color <= color_r;
            prev_shape <= shape_r;
            match_cnt  <= match_new;
        end
    end
`else
    assign publish = 1'b1;
`endif

    logic [1:0] res_color, res_shape;
    logic       res_valid;

    // Registered result pins with a one-cycle valid pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            res_color <= '0;
            res_shape <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if ((state == ST_COMMIT) && publish) begin
                res_color <= color_r;
                res_shape <= shape_r;
                res_valid <= 1'b1;
            end
        end
    end

    assign bus.RESULT_COLOR = res_color;
    assign bus.RESULT_SHAPE = res_shape;
    assign bus.RESULT_VALID = res_valid;

endmodule
